// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Circular successor of idx within n slots.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/muxn.sv
// Generic N:1 data multiplexer over a flat N*W input bus.
module muxn #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N*W-1:0]       data_i,
    input  logic [$clog2(N)-1:0] sel_i,
    output logic [W-1:0]         data_o
);

    logic [W-1:0] words [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign words[gi] = data_i[gi*W +: W];
        end
    endgenerate

    assign data_o = words[sel_i];

endmodule

// File: rtl/rr_arbiter_pick.sv
// Circular find-first: first valid requester after last_grant, wrapping modulo N.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] last_grant_i,
    output logic [$clog2(N)-1:0] winner_o,
    output logic                 any_valid_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] search_idx;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        search_idx  = IW'(next_index(int'(last_grant_i), N));
        for (int k = 0; k < N; k++) begin
            if (!any_valid_o && valid_i[search_idx]) begin
                any_valid_o = 1'b1;
                winner_o    = search_idx;
            end
            search_idx = IW'(next_index(int'(search_idx), N));
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with packet locking; one registered output beat, latency 1.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_last,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_id,
    output logic                 out_last
);

    localparam int IW = $clog2(N);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_grant_q, last_grant_d;

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [IW-1:0] out_id_q;
    logic          out_last_q;

    logic          can_load;
    logic [IW-1:0] pick_winner;
    logic          pick_any;
    logic [IW-1:0] grant_idx;
    logic          grant_en;
    logic          grant_last;
    logic [W-1:0]  mux_data;

    rr_pick #(.N(N)) u_pick (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_winner),
        .any_valid_o  (pick_any)
    );

    muxn #(.N(N), .W(W)) u_mux (
        .data_i (req_data),
        .sel_i  (grant_idx),
        .data_o (mux_data)
    );

    // A stalled output register blocks every grant; a locked owner blocks all others.
    always_comb begin
        can_load     = !out_valid_q || out_ready;
        grant_idx    = pick_winner;
        grant_en     = 1'b0;
        grant_last   = 1'b0;
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                grant_idx  = pick_winner;
                grant_en   = can_load && pick_any;
                grant_last = req_last[pick_winner];
                if (grant_en) begin
                    last_grant_d = pick_winner;
                    if (!grant_last) begin
                        state_d = BUSY;
                        owner_d = pick_winner;
                    end
                end
            end
            BUSY: begin
                grant_idx  = owner_q;
                grant_en   = can_load && req_valid[owner_q];
                grant_last = req_last[owner_q];
                if (grant_en && grant_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IW'(N - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
        end else if (grant_en) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_id_q    <= grant_idx;
            out_last_q  <= grant_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;

endmodule
